// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the fetch/execute pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TRAP     = 2'b10
  } pipe_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_TRAP   = 2'b10
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_event_counter.sv
// Wrapping event counter with synchronous clear and increment enable.
module pipe_event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch/execute pipeline sequencer: PC advance, pipe load/flush, memory stalls,
// branch redirects and interrupt entry, plus stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               imem_valid,
  input  logic               mem_op_execute,
  input  logic               dmem_ready,
  input  logic               br_taken_execute,
  input  logic               irq_pending,
  input  logic               irq_enable,
  output logic               dmem_req,
  output logic               pc_enable,
  output logic [1:0]         pc_sel,
  output logic               pipe_enable,
  output logic               pipe_flush,
  output logic               kill_execute,
  output logic               trap_taken,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  pipe_state_e state_q, state_d;
  pc_sel_e     pc_sel_c;
  logic        advance;
  logic        bubble;
  logic        irq_take;
  logic        stall_inc;
  logic        flush_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupts are deferred while a memory op is in execute so it is never half-done.
  assign irq_take = irq_pending & irq_enable & ~mem_op_execute;

  always_comb begin
    state_d      = state_q;
    dmem_req     = 1'b0;
    pc_enable    = 1'b1;
    pc_sel_c     = PC_PLUS4;
    pipe_enable  = 1'b1;
    pipe_flush   = 1'b0;
    kill_execute = 1'b0;
    trap_taken   = 1'b0;
    advance      = 1'b0;
    bubble       = 1'b0;
    flush_inc    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (irq_take) begin
          trap_taken   = 1'b1;
          kill_execute = 1'b1;
          pc_sel_c     = PC_TRAP;
          pipe_flush   = 1'b1;
          flush_inc    = 1'b1;
          state_d      = TRAP;
        end else if (mem_op_execute && !dmem_ready) begin
          dmem_req    = 1'b1;
          pc_enable   = 1'b0;
          pipe_enable = 1'b0;
          state_d     = MEM_WAIT;
        end else begin
          dmem_req = mem_op_execute;
          advance  = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          advance = 1'b1;
          state_d = RUN;
        end else begin
          pc_enable   = 1'b0;
          pipe_enable = 1'b0;
        end
      end
      TRAP: begin
        pipe_flush = ~imem_valid;
        bubble     = ~imem_valid;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Normal sequencing: redirect beats a missing fetch so the target gets fetched.
    if (advance) begin
      if (br_taken_execute) begin
        pc_sel_c   = PC_TARGET;
        pipe_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (!imem_valid) begin
        pc_enable  = 1'b0;
        pipe_flush = 1'b1;
        bubble     = 1'b1;
      end
    end

    if (reset) begin
      state_d      = RUN;
      dmem_req     = 1'b0;
      pc_enable    = 1'b0;
      pc_sel_c     = PC_PLUS4;
      pipe_enable  = 1'b1;
      pipe_flush   = 1'b1;
      kill_execute = 1'b0;
      trap_taken   = 1'b0;
      bubble       = 1'b0;
      flush_inc    = 1'b0;
    end

    stall_inc = ~pipe_enable | bubble;
  end

  assign pc_sel = 2'(pc_sel_c);

  pipe_event_counter #(
    .WIDTH(COUNT_W)
  ) u_stall_cnt (
    .clk_i  (clock),
    .clear_i(reset),
    .inc_i  (stall_inc),
    .count_o(stall_count)
  );

  pipe_event_counter #(
    .WIDTH(COUNT_W)
  ) u_flush_cnt (
    .clk_i  (clock),
    .clear_i(reset),
    .inc_i  (flush_inc),
    .count_o(flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs are queued when inputs are
// driven and compared on the following falling edge.
module tb_pipe_ctrl;

  localparam int unsigned COUNT_W = 32;

  logic               clock;
  logic               reset;
  logic               imem_valid;
  logic               mem_op_execute;
  logic               dmem_ready;
  logic               br_taken_execute;
  logic               irq_pending;
  logic               irq_enable;
  logic               dmem_req;
  logic               pc_enable;
  logic [1:0]         pc_sel;
  logic               pipe_enable;
  logic               pipe_flush;
  logic               kill_execute;
  logic               trap_taken;
  logic [COUNT_W-1:0] stall_count;
  logic [COUNT_W-1:0] flush_count;

  pipe_ctrl #(.COUNT_W(COUNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_valid      (imem_valid),
    .mem_op_execute  (mem_op_execute),
    .dmem_ready      (dmem_ready),
    .br_taken_execute(br_taken_execute),
    .irq_pending     (irq_pending),
    .irq_enable      (irq_enable),
    .dmem_req        (dmem_req),
    .pc_enable       (pc_enable),
    .pc_sel          (pc_sel),
    .pipe_enable     (pipe_enable),
    .pipe_flush      (pipe_flush),
    .kill_execute    (kill_execute),
    .trap_taken      (trap_taken),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic        pcen;
    logic [1:0]  sel;
    logic        pe;
    logic        pf;
    logic        kill;
    logic        trap;
    logic        cnt_valid;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: 0 = run, 1 = waiting on data memory, 2 = trap cycle.
  int          m_state = 0;
  logic        m_known = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("dmem_req",     32'(dmem_req),     32'(e.req));
      check("pc_enable",    32'(pc_enable),    32'(e.pcen));
      check("pc_sel",       32'(pc_sel),       32'(e.sel));
      check("pipe_enable",  32'(pipe_enable),  32'(e.pe));
      check("pipe_flush",   32'(pipe_flush),   32'(e.pf));
      check("kill_execute", 32'(kill_execute), 32'(e.kill));
      check("trap_taken",   32'(trap_taken),   32'(e.trap));
      if (e.cnt_valid) begin
        check("stall_count", stall_count, e.stall);
        check("flush_count", flush_count, e.flush);
      end
    end
  end

  // Apply one cycle of inputs, queue the model's expectation, then advance one edge.
  task automatic drive(input logic rst, input logic iv, input logic mem, input logic rdy,
                       input logic br, input logic irq, input logic ien);
    exp_t e;
    int   nst;
    logic st_ev, fl_ev, adv;
    reset = rst; imem_valid = iv; mem_op_execute = mem; dmem_ready = rdy;
    br_taken_execute = br; irq_pending = irq; irq_enable = ien;

    e.req = 1'b0; e.pcen = 1'b1; e.sel = 2'b00; e.pe = 1'b1; e.pf = 1'b0;
    e.kill = 1'b0; e.trap = 1'b0;
    e.cnt_valid = m_known; e.stall = m_stall; e.flush = m_flush;
    st_ev = 1'b0; fl_ev = 1'b0; adv = 1'b0; nst = m_state;

    if (rst) begin
      e.pcen = 1'b0; e.pf = 1'b1; nst = 0;
    end else if (m_state == 2) begin
      e.pf = !iv; st_ev = !iv; nst = 0;
    end else if (m_state == 0 && irq && ien && !mem) begin
      e.trap = 1'b1; e.kill = 1'b1; e.sel = 2'b10; e.pf = 1'b1; fl_ev = 1'b1; nst = 2;
    end else if (mem && !rdy) begin
      e.req = 1'b1; e.pcen = 1'b0; e.pe = 1'b0; st_ev = 1'b1; nst = 1;
    end else if (m_state == 1 && !rdy) begin
      e.req = 1'b1; e.pcen = 1'b0; e.pe = 1'b0; st_ev = 1'b1;
    end else begin
      e.req = mem || (m_state == 1);
      adv = 1'b1; nst = 0;
    end

    if (adv) begin
      if (br) begin
        e.sel = 2'b01; e.pf = 1'b1; fl_ev = 1'b1;
      end else if (!iv) begin
        e.pcen = 1'b0; e.pf = 1'b1; st_ev = 1'b1;
      end
    end

    sb.push_back(e);
    @(posedge clock);
    #1;
    m_state = nst;
    if (rst) begin
      m_known = 1'b1; m_stall = '0; m_flush = '0;
    end else begin
      m_stall = m_stall + 32'(st_ev);
      m_flush = m_flush + 32'(fl_ev);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b1; mem_op_execute = 1'b0; dmem_ready = 1'b0;
    br_taken_execute = 1'b0; irq_pending = 1'b0; irq_enable = 1'b0;
    @(posedge clock);
    #1;

    // Reset, then normal sequential fetch.
    do_reset(2);
    check("rst_stall_zero", stall_count, 32'd0);
    check("rst_flush_zero", flush_count, 32'd0);
    idle(2);

    // Memory op waiting three cycles, ready on the fourth.
    do_reset(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mem_stall_cnt", stall_count, 32'd3);
    // Ready in the first cycle: no stall at all; stray ready without a mem op is ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mem_fast_cnt", stall_count, 32'd3);

    // Single taken branch.
    do_reset(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("br_flush_cnt", flush_count, 32'd1);

    // Branch with interrupt: trap wins; irq still high through the trap cycle.
    do_reset(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("irq_flush_cnt", flush_count, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Two fetch bubbles, then branch together with a missing fetch.
    do_reset(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bubble_stall_cnt", stall_count, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_bubble_stall", stall_count, 32'd2);

    // Interrupt deferred by a memory op, then taken with a bubble in the trap cycle.
    do_reset(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset asserted in the middle of a memory wait.
    do_reset(1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 0));
    end

    @(negedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Sequencing controller for the two-stage fetch/execute pipeline. It decides each cycle whether the PC advances, whether the fetch→execute pipeline register loads, and whether it loads the fetched instruction or a NOP bubble (32'h00000013). It also stalls on data-memory handshakes, redirects on taken branches and jumps, and takes interrupts. Two performance counters track stall cycles and flush events.

## Interface
Parameters:
- COUNT_W, 32: width of both performance counters.

Ports:
- clock  in  1  single clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_valid  in  1  fetched instruction is valid this cycle.
- mem_op_execute  in  1  the instruction in execute is a load or store.
- dmem_ready  in  1  data memory has completed the request.
- br_taken_execute  in  1  the branch in execute is taken, or the instruction is a jump.
- irq_pending  in  1  level interrupt request.
- irq_enable  in  1  global interrupt enable.
- dmem_req  out  1  data-memory request, held high until ready.
- pc_enable  out  1  PC register loads its next value.
- pc_sel  out  2  next-PC select (PC_PLUS4, PC_TARGET, PC_TRAP).
- pipe_enable  out  1  fetch→execute register loads.
- pipe_flush  out  1  the register loads NOP instead of the fetched instruction.
- kill_execute  out  1  suppresses writeback and memory side effects of the instruction in execute.
- trap_taken  out  1  one-cycle pulse; the EPC captures pc_execute.
- stall_count  out  COUNT_W  cycles with pipe_enable=0 or with a fetch bubble.
- flush_count  out  COUNT_W  number of redirect events (branch or trap).

## Operation
States: RUN, MEM_WAIT, TRAP.

In RUN, priorities are evaluated top-down each cycle:
1. Interrupt: `irq_pending & irq_enable & !mem_op_execute`.
   - Outputs: trap_taken=1, kill_execute=1, pc_sel=PC_TRAP, pc_enable=1, pipe_enable=1, pipe_flush=1.
   - Next state: TRAP.
2. Memory op: `mem_op_execute`.
   - dmem_req=1.
   - If dmem_ready is high the same cycle, the pipeline proceeds normally (rules 3–5 apply).
   - Otherwise pc_enable=0, pipe_enable=0, and the next state is MEM_WAIT.
3. Branch: `br_taken_execute`.
   - Outputs: pc_sel=PC_TARGET, pc_enable=1, pipe_enable=1, pipe_flush=1.
   - The branch instruction itself retires.
4. Fetch bubble: `!imem_valid`.
   - Outputs: pc_enable=0, pipe_enable=1, pipe_flush=1.
5. Otherwise: pc_sel=PC_PLUS4, pc_enable=1, pipe_enable=1, pipe_flush=0.

MEM_WAIT:
- dmem_req=1, pc_enable=0, pipe_enable=0.
- On dmem_ready, rules 3–5 of RUN apply in that cycle and the next state is RUN.
- irq_pending is ignored in this state.

TRAP (exactly one cycle):
- Execute holds a NOP; pc_enable=1, pc_sel=PC_PLUS4, pipe_enable=1.
- pipe_flush follows rule 4.
- Interrupts and branches are ignored.
- Next state: RUN.

Counters:
- stall_count increments in every cycle where pipe_enable=0, or pipe_flush=1 due to rule 4.
- flush_count increments on each rule-1 or rule-3 event.
- Both wrap modulo 2^COUNT_W.

## Timing
- All controls are combinational from state and inputs. Zero latency: the redirect, flush and stall take effect at the next edge.
- Branch penalty is exactly one bubble. The interrupt penalty is one killed instruction plus one bubble.
- dmem_req stays high from the first cycle of a memory op until the cycle dmem_ready is seen, inclusive.
- Reset:
  - While reset is high, outputs are forced to pc_enable=0, pipe_enable=1, pipe_flush=1, pc_sel=PC_PLUS4, dmem_req=0, trap_taken=0, kill_execute=0.
  - At the edge, state becomes RUN and both counters become 0.
  - Reset asserted in MEM_WAIT drops dmem_req in the same cycle.
- Simultaneous events:
  - Branch and irq with no memory op: the trap wins and the branch is killed (EPC = branch PC).
  - Branch and !imem_valid: the branch wins, and pc_enable=1 so the target is fetched.
  - dmem_ready high while mem_op_execute is low: ignored.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - enum `pipe_state_e` (RUN, MEM_WAIT, TRAP)
  - `pc_sel_e`: PC_PLUS4=2'b00, PC_TARGET=2'b01, PC_TRAP=2'b10
  - localparam `NOP_INSTR` = 32'h00000013
- The natural sub-module is `pipe_event_counter`: a parameterised wrapping counter with synchronous clear and an increment enable, instantiated twice.

## Test plan
- Reset for 2 cycles, then release with imem_valid=1 and no events. Expect pipe_flush=1 and pc_enable=0 during reset, counters at 0, then pc_sel=00, pc_enable=1, pipe_flush=0.
- mem_op_execute=1 with dmem_ready low for 3 cycles. Expect dmem_req high for 4 cycles, pipe_enable=0 for 3 cycles, and stall_count=3.
- br_taken_execute=1 for one cycle. Expect pc_sel=01, pipe_flush=1, flush_count=1, and kill_execute=0.
- irq_pending=1 and irq_enable=1 together with br_taken_execute=1. Expect trap_taken and kill_execute pulsed for 1 cycle, pc_sel=10, the TRAP cycle ignoring the still-high irq, and flush_count=1.
- imem_valid=0 for 2 cycles. Expect pc_enable=0, pipe_flush=1, and stall_count=2.
- Assert reset mid-MEM_WAIT. Expect dmem_req low in the same cycle and RUN after the edge.
